// File: rtl/avmm_mul_initiator.sv
// avmm_mul_initiator
// Avalon-MM write initiator for the doubling-multiplier slave
// (reg 0 = A, reg 1 = B, conduit R = A*B*2).
// The block takes one operand pair, writes A then B, waits SETTLE cycles after
// the B write completes, captures R and then offers it on a valid/ready output.
//
// Ports:
//   clk, srst             clock, synchronous active-high reset
//   in_valid/in_ready     operand pair handshake; in_a, in_b are the operands
//   avm_m0_*              Avalon-MM write initiator (address, write, writedata,
//                         waitrequest)
//   R_in                  conduit result from the slave
//   res_valid/res_ready   result handshake; res_data is the captured R
//   txn_count             completed result handshakes, wraps at 16 bits
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// WR_A  | writing operand A to address 0, held while waitrequest
// WR_B  | writing operand B to address 1, held while waitrequest
// WAIT  | settle down-counter running; R_in captured at terminal count
// DONE  | res_valid high, waiting for res_ready
module avmm_mul_initiator #(
    parameter int N      = 32,
    parameter int SETTLE = 2
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    output logic [7:0]   avm_m0_address,
    output logic         avm_m0_write,
    output logic [N-1:0] avm_m0_writedata,
    input  logic         avm_m0_waitrequest,
    input  logic [N-1:0] R_in,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic [15:0]  txn_count
);

    typedef enum logic [2:0] {IDLE, WR_A, WR_B, WAIT, DONE} state_t;

    state_t       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [N-1:0] op_b_q, op_b_d;

    logic         in_ready_d;
    logic         write_d;
    logic [7:0]   address_d;
    logic [N-1:0] writedata_d;
    logic         res_valid_d;
    logic [N-1:0] res_data_d;
    logic [15:0]  txn_count_d;

    logic wr_done;
    logic accept;
    logic res_hs;

    assign wr_done = avm_m0_write && !avm_m0_waitrequest;
    assign accept  = in_valid && in_ready;
    assign res_hs  = res_valid && res_ready;

    // State and all output registers; every output is a flop.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            op_b_q           <= '0;
            in_ready         <= 1'b0;
            avm_m0_write     <= 1'b0;
            avm_m0_address   <= '0;
            avm_m0_writedata <= '0;
            res_valid        <= 1'b0;
            res_data         <= '0;
            txn_count        <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            op_b_q           <= op_b_d;
            in_ready         <= in_ready_d;
            avm_m0_write     <= write_d;
            avm_m0_address   <= address_d;
            avm_m0_writedata <= writedata_d;
            res_valid        <= res_valid_d;
            res_data         <= res_data_d;
            txn_count        <= txn_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = WR_A;
            WR_A:    if (wr_done)    state_d = WR_B;
            WR_B:    if (wr_done)    state_d = WAIT;
            WAIT:    if (cnt_q == 0) state_d = DONE;
            DONE:    if (res_hs)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Next values for the registered outputs, derived from the state being
    // entered so that each output is valid in the same cycle as its state.
    always_comb begin
        in_ready_d  = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
        write_d     = 1'b0;
        address_d   = avm_m0_address;
        writedata_d = avm_m0_writedata;
        cnt_d       = cnt_q;
        op_b_d      = op_b_q;
        res_data_d  = res_data;
        txn_count_d = txn_count;

        case (state_d)
            WR_A: begin
                write_d   = 1'b1;
                address_d = 8'd0;
                // A goes straight into writedata on the accepting edge.
                if (state_q == IDLE) begin
                    writedata_d = in_a;
                    op_b_d      = in_b;
                end
            end
            WR_B: begin
                write_d     = 1'b1;
                address_d   = 8'd1;
                writedata_d = op_b_q;
            end
            default: ;
        endcase

        if (state_q == WR_B && wr_done)
            cnt_d = 4'(SETTLE - 1);
        else if (state_q == WAIT && cnt_q != 0)
            cnt_d = cnt_q - 4'd1;

        if (state_q == WAIT && cnt_q == 0)
            res_data_d = R_in;

        if (state_q == DONE && res_hs)
            txn_count_d = txn_count + 16'd1;
    end

endmodule

// File: tb/tb_avmm_mul_initiator.sv
module tb_avmm_mul_initiator;

    logic        clk = 1'b0;
    logic        srst = 1'b1;

    // DUT with SETTLE = 2
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_a = '0, in_b = '0;
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic        wreq = 1'b0;
    logic [31:0] r_in;
    logic        res_valid, res_ready = 1'b0;
    logic [31:0] res_data;
    logic [15:0] txn_count;

    // DUT with SETTLE = 5
    logic        in_valid5 = 1'b0, in_ready5;
    logic [31:0] in_a5 = '0, in_b5 = '0;
    logic [7:0]  addr5;
    logic        wr5;
    logic [31:0] wdata5;
    logic [31:0] r_in5;
    logic        res_valid5, res_ready5 = 1'b0;
    logic [31:0] res_data5;
    logic [15:0] txn_count5;

    always #5 clk = ~clk;

    avmm_mul_initiator #(.N(32), .SETTLE(2)) dut (
        .clk(clk), .srst(srst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .avm_m0_address(addr), .avm_m0_write(wr), .avm_m0_writedata(wdata),
        .avm_m0_waitrequest(wreq), .R_in(r_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .txn_count(txn_count)
    );

    avmm_mul_initiator #(.N(32), .SETTLE(5)) dut5 (
        .clk(clk), .srst(srst),
        .in_valid(in_valid5), .in_ready(in_ready5), .in_a(in_a5), .in_b(in_b5),
        .avm_m0_address(addr5), .avm_m0_write(wr5), .avm_m0_writedata(wdata5),
        .avm_m0_waitrequest(1'b0), .R_in(r_in5),
        .res_valid(res_valid5), .res_ready(res_ready5), .res_data(res_data5),
        .txn_count(txn_count5)
    );

    // Behavioural doubling-multiplier slaves: operand regs update on the
    // accepted write edge, R one edge later.
    logic [31:0] s_a, s_b, s_r, s_a5, s_b5, s_r5;
    always @(posedge clk) begin
        if (srst) begin
            s_a <= '0; s_b <= '0; s_r <= '0;
        end else begin
            if (wr && !wreq) begin
                if (addr == 8'd0) s_a <= wdata;
                else if (addr == 8'd1) s_b <= wdata;
            end
            s_r <= s_a * s_b * 32'd2;
        end
    end
    always @(posedge clk) begin
        if (srst) begin
            s_a5 <= '0; s_b5 <= '0; s_r5 <= '0;
        end else begin
            if (wr5) begin
                if (addr5 == 8'd0) s_a5 <= wdata5;
                else if (addr5 == 8'd1) s_b5 <= wdata5;
            end
            s_r5 <= s_a5 * s_b5 * 32'd2;
        end
    end
    assign r_in  = s_r;
    assign r_in5 = s_r5;

    // Edge counter: after edge k (sampled at #1 or at the negedge) cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t wr_log[$];
    always @(posedge clk)
        if (!srst && wr && !wreq) wr_log.push_back('{cyc + 1, addr, wdata});

    int acc_cnt = 0;
    always @(posedge clk)
        if (!srst && in_valid && in_ready) acc_cnt <= acc_cnt + 1;

    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          acc_cyc = 0;
    int          exp_txn = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present a pair and return once it has been accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input bit push, input bit hold, output bit ok);
        int t;
        @(negedge clk);
        in_a = a; in_b = b; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = in_ready;
        if (ok) begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            if (push) exp_q.push_back(a * b * 32'd2);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    // Wait for res_valid, optionally stall res_ready, then take the result.
    task automatic get_result(input int delay, output logic [31:0] data,
                              output int lat, output bit ok, output bit held_ok);
        int t;
        t = 0;
        held_ok = 1'b1;
        data = '0;
        lat = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!res_valid && t < 200);
        ok = res_valid;
        if (ok) begin
            lat  = cyc - acc_cyc;
            data = res_data;
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                if (!res_valid || res_data !== data || in_ready !== 1'b0 ||
                    txn_count !== 16'(exp_txn))
                    held_ok = 1'b0;
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            exp_txn++;
        end
    endtask

    task automatic test_reset;
        srst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            $display("FAIL reset_in_ready got %0b want 0", in_ready); n_fail++;
        end
        n_cmp++;
        if ({wr, addr, wdata} !== 41'd0) begin
            $display("FAIL reset_avm got write=%0b addr=%0d data=%0h want 0", wr, addr, wdata); n_fail++;
        end
        n_cmp++;
        if ({res_valid, res_data, txn_count} !== 49'd0) begin
            $display("FAIL reset_res got valid=%0b data=%0h txn=%0d want 0", res_valid, res_data, txn_count); n_fail++;
        end
        @(negedge clk);
        srst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_idle_ready got %0b want 1", in_ready); n_fail++;
        end
        exp_txn = 0;
    endtask

    task automatic test_basic;
        bit ok, ok2, h;
        logic [31:0] d, e;
        int lat;
        wr_log.delete();
        send(32'd3, 32'd5, 1'b1, 1'b0, ok);
        get_result(0, d, lat, ok2, h);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || !ok2) begin
            $display("FAIL basic_timeout accepted=%0b result=%0b want 1/1", ok, ok2); n_fail++;
        end
        n_cmp++;
        if (d !== e) begin
            $display("FAIL basic_data got %0d want %0d", d, e); n_fail++;
        end
        n_cmp++;
        if (lat != 4) begin
            $display("FAIL basic_latency got %0d want 4", lat); n_fail++;
        end
        n_cmp++;
        if (wr_log.size() != 2) begin
            $display("FAIL basic_write_count got %0d want 2", wr_log.size()); n_fail++;
        end else begin
            n_cmp++;
            if (wr_log[0].a !== 8'd0 || wr_log[0].d !== 32'd3 || wr_log[0].c != acc_cyc + 1) begin
                $display("FAIL basic_write_a got addr=%0d data=%0d edge=+%0d want 0/3/+1",
                         wr_log[0].a, wr_log[0].d, wr_log[0].c - acc_cyc); n_fail++;
            end
            n_cmp++;
            if (wr_log[1].a !== 8'd1 || wr_log[1].d !== 32'd5 || wr_log[1].c != acc_cyc + 2) begin
                $display("FAIL basic_write_b got addr=%0d data=%0d edge=+%0d want 1/5/+2",
                         wr_log[1].a, wr_log[1].d, wr_log[1].c - acc_cyc); n_fail++;
            end
        end
        n_cmp++;
        if (txn_count !== 16'(exp_txn) || res_valid !== 1'b0) begin
            $display("FAIL basic_txn got txn=%0d valid=%0b want %0d/0", txn_count, res_valid, exp_txn); n_fail++;
        end
    endtask

    task automatic test_stall;
        bit ok, ok2, h, stable;
        logic [31:0] d, e;
        int lat;
        wr_log.delete();
        stable = 1'b1;
        wreq = 1'b1;
        send(32'd7, 32'd9, 1'b1, 1'b0, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({wr, addr, wdata} !== {1'b1, 8'd0, 32'd7}) stable = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        if ({wr, addr, wdata} !== {1'b1, 8'd0, 32'd7}) stable = 1'b0;
        wreq = 1'b0;
        @(posedge clk);
        #1;
        wreq = 1'b1;
        @(negedge clk);
        if ({wr, addr, wdata} !== {1'b1, 8'd1, 32'd9}) stable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if ({wr, addr, wdata} !== {1'b1, 8'd1, 32'd9}) stable = 1'b0;
        wreq = 1'b0;
        get_result(0, d, lat, ok2, h);
        e = exp_q.pop_front();
        n_cmp++;
        if (!stable) begin
            $display("FAIL stall_stable got unstable write/addr/data want held"); n_fail++;
        end
        n_cmp++;
        if (d !== e || !ok || !ok2) begin
            $display("FAIL stall_data got %0d want %0d", d, e); n_fail++;
        end
        n_cmp++;
        if (lat != 8) begin
            $display("FAIL stall_latency got %0d want 8", lat); n_fail++;
        end
        n_cmp++;
        if (wr_log.size() != 2) begin
            $display("FAIL stall_write_count got %0d want 2", wr_log.size()); n_fail++;
        end else begin
            n_cmp++;
            if (wr_log[0].a !== 8'd0 || wr_log[0].d !== 32'd7 ||
                wr_log[1].a !== 8'd1 || wr_log[1].d !== 32'd9) begin
                $display("FAIL stall_writes got %0d:%0d %0d:%0d want 0:7 1:9",
                         wr_log[0].a, wr_log[0].d, wr_log[1].a, wr_log[1].d); n_fail++;
            end
        end
    endtask

    task automatic test_overflow;
        bit ok, ok2, h;
        logic [31:0] d, e;
        int lat;
        send(32'h8000_0000, 32'd1, 1'b1, 1'b0, ok);
        get_result(0, d, lat, ok2, h);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== 32'h0000_0000 || !ok || !ok2) begin
            $display("FAIL overflow_msb got %0h want 00000000", d); n_fail++;
        end
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, ok);
        get_result(0, d, lat, ok2, h);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== 32'h0000_0002 || !ok || !ok2) begin
            $display("FAIL overflow_all_ones got %0h want 00000002", d); n_fail++;
        end
    endtask

    task automatic test_backpressure;
        bit ok, ok2, h;
        logic [31:0] d, e;
        int lat;
        send(32'd3, 32'd5, 1'b1, 1'b0, ok);
        get_result(4, d, lat, ok2, h);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== e || !ok || !ok2) begin
            $display("FAIL bp_data got %0d want %0d", d, e); n_fail++;
        end
        n_cmp++;
        if (!h) begin
            $display("FAIL bp_hold got valid/data/in_ready/txn changed want held"); n_fail++;
        end
        n_cmp++;
        if (txn_count !== 16'(exp_txn)) begin
            $display("FAIL bp_txn got %0d want %0d", txn_count, exp_txn); n_fail++;
        end
    endtask

    task automatic test_reset_mid_write;
        bit ok, ok2, h;
        logic [31:0] d, e;
        int lat;
        wreq = 1'b0;
        send(32'd6, 32'd7, 1'b0, 1'b0, ok);
        @(posedge clk);
        #1;
        wreq = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({wr, addr} !== {1'b1, 8'd1}) begin
            $display("FAIL rst_mid_in_wr_b got write=%0b addr=%0d want 1/1", wr, addr); n_fail++;
        end
        srst = 1'b1;
        @(posedge clk);
        #1;
        srst = 1'b0;
        wreq = 1'b0;
        exp_txn = 0;
        n_cmp++;
        if (wr !== 1'b0 || res_valid !== 1'b0) begin
            $display("FAIL rst_mid_drop got write=%0b valid=%0b want 0/0", wr, res_valid); n_fail++;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || txn_count !== 16'd0) begin
            $display("FAIL rst_mid_idle got in_ready=%0b txn=%0d want 1/0", in_ready, txn_count); n_fail++;
        end
        send(32'd2, 32'd4, 1'b1, 1'b0, ok);
        get_result(0, d, lat, ok2, h);
        e = exp_q.pop_front();
        n_cmp++;
        if (d !== 32'd16 || e !== 32'd16 || !ok || !ok2) begin
            $display("FAIL rst_mid_next got %0d want 16", d); n_fail++;
        end
    endtask

    task automatic test_back_to_back;
        int acc0;
        acc0 = acc_cnt;
        fork
            begin
                bit ok;
                send(32'd1, 32'd2, 1'b1, 1'b1, ok);
                send(32'd3, 32'd4, 1'b1, 1'b1, ok);
                send(32'd5, 32'd6, 1'b1, 1'b0, ok);
            end
            begin
                bit ok2, h;
                logic [31:0] d, e;
                int lat;
                for (int k = 0; k < 3; k++) begin
                    get_result(0, d, lat, ok2, h);
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    n_cmp++;
                    if (d !== e || !ok2) begin
                        $display("FAIL b2b_data_%0d got %0d want %0d", k, d, e); n_fail++;
                    end
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (acc_cnt - acc0 != 3) begin
            $display("FAIL b2b_accepts got %0d want 3", acc_cnt - acc0); n_fail++;
        end
        n_cmp++;
        if (txn_count !== 16'(exp_txn) || exp_txn != 4) begin
            $display("FAIL b2b_txn got %0d want 4", txn_count); n_fail++;
        end
    endtask

    task automatic test_settle5;
        int t, a5, lat;
        logic [31:0] e;
        @(negedge clk);
        in_a5 = 32'd4; in_b5 = 32'd5; in_valid5 = 1'b1;
        t = 0;
        while (!in_ready5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        a5 = cyc;
        in_valid5 = 1'b0;
        exp_q.push_back(32'd4 * 32'd5 * 32'd2);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!res_valid5 && t < 200);
        lat = cyc - a5;
        e = exp_q.pop_front();
        n_cmp++;
        if (lat != 7) begin
            $display("FAIL settle5_latency got %0d want 7", lat); n_fail++;
        end
        n_cmp++;
        if (res_data5 !== e || !res_valid5) begin
            $display("FAIL settle5_data got %0d want %0d", res_data5, e); n_fail++;
        end
        res_ready5 = 1'b1;
        @(posedge clk);
        #1;
        res_ready5 = 1'b0;
        n_cmp++;
        if (txn_count5 !== 16'd1 || res_valid5 !== 1'b0) begin
            $display("FAIL settle5_txn got txn=%0d valid=%0b want 1/0", txn_count5, res_valid5); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_overflow();
        test_backpressure();
        test_reset_mid_write();
        test_back_to_back();
        test_settle5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/avmm_mul_initiator.md
Name: avmm_mul_initiator

Overview:
- Avalon-MM write initiator that drives the team's doubling-multiplier slave: register 0 = operand A, register 1 = operand B, conduit R = A*B*2.
- Accepts an operand pair on a valid/ready input, issues the two register writes with waitrequest handling, waits for the slave's registered result to settle, captures conduit R, and presents the result on a valid/ready output.
- Sits between a streaming producer and the multiplier slave in the same Platform Designer system.

Parameters:
- N, 32, data width of operands, writedata, conduit R and result.
- SETTLE, 2, cycles from the accepting edge of the operand-B write to the capture of R; legal range 2..15.

Ports:
- clk  input  1  clock.
- srst  input  1  synchronous active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  N  operand A.
- in_b  input  N  operand B.
- avm_m0_address  output  8  Avalon-MM address.
- avm_m0_write  output  1  Avalon-MM write strobe.
- avm_m0_writedata  output  N  Avalon-MM write data.
- avm_m0_waitrequest  input  1  slave stall; tie to 0 if the slave has none.
- R_in  input  N  conduit result from the slave.
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  N  captured R.
- txn_count  output  16  completed transactions, incremented on result handshake; wraps 0xFFFF->0.

Behaviour:
- Reset values: in_ready=0 during the reset cycle, then 1 in IDLE; avm_m0_write=0; avm_m0_address=0; avm_m0_writedata=0; res_valid=0; res_data=0; txn_count=0; state=IDLE.
- Reset takes priority over every other event on any edge.
- FSM states: IDLE, WR_A, WR_B, WAIT, DONE.

IDLE:
- in_ready=1.
- On an edge with in_valid&&in_ready: latch in_a and in_b, then go to WR_A.

WR_A:
- Drive avm_m0_write=1, address=0, writedata=A.
- The transfer completes on an edge with avm_m0_write && !avm_m0_waitrequest; then go to WR_B.
- While waitrequest=1, address, writedata and write are held stable.

WR_B:
- Same as WR_A with address=1 and writedata=B.
- On completion, load cnt=SETTLE-1 and go to WAIT.

WAIT:
- avm_m0_write=0.
- Each edge: if cnt==0, capture res_data<=R_in and go to DONE; otherwise cnt<=cnt-1.
- R_in is therefore sampled at edge e0+SETTLE, where e0 is the B-write accepting edge.
- SETTLE=2 matches the slave: its operand register updates at e0 and R at e0+1.

DONE:
- res_valid=1 and res_data is held.
- On an edge with res_valid&&res_ready: txn_count++, res_valid<=0, go to IDLE.
- in_ready=0 in every state other than IDLE; no overlap between transactions.

General rules:
- Minimum transaction latency with no stalls: accept edge -> A write edge +1 -> B write edge +2 -> capture at +2+SETTLE -> res_valid high from then on.
- Arithmetic is done by the slave; res_data is exactly R_in, with no width change.
- Expected value for checking is (A*B*2) mod 2^N.
- Outputs avm_m0_* and res_* are registered, with no combinational path from any input to them.
- in_valid is sampled only in IDLE; in_a and in_b are ignored elsewhere.
- Reset mid-operation (any state): at the srst edge, avm_m0_write drops and the in-flight write is abandoned. res_valid drops, and latched operands are discarded. The slave is reset by the same srst.

Test Plan:
- Basic: waitrequest=0, SETTLE=2, A=3, B=5 -> writes (addr 0, 3) at accept+1 and (addr 1, 5) at accept+2; res_data=30 and res_valid rise at accept+4.
- Stall: waitrequest held high 3 cycles in WR_A and 1 cycle in WR_B with A=7, B=9 -> address/data/write stable through every stall; exactly one accepted write per address; res_data=126.
- Overflow: N=32, A=0x80000000, B=1 -> res_data=0. Then A=0xFFFFFFFF, B=0xFFFFFFFF -> res_data=0x00000002.
- Backpressure: res_ready low for 4 cycles after res_valid -> res_valid and res_data=30 held, in_ready=0, txn_count unchanged; increments by 1 on handshake.
- Reset mid-write: assert srst for 1 cycle while in WR_B with waitrequest=1 -> next cycle avm_m0_write=0, res_valid=0, in_ready=1 after reset. A following pair A=2, B=4 yields 16.
- Back-to-back: 3 pairs presented with in_valid held high -> each accepted only in IDLE, results 2*A*B in order; txn_count=3; SETTLE=5 run shifts capture by 3 cycles.
